// File: rtl/seq_divmod.sv
// ----------------------------------------------------------------------------
// seq_divmod
//   Multi-cycle restoring integer divider: quotient = a / b, remainder = a % b,
//   one quotient bit per clock, start/done handshake, divide-by-zero flag.
//
//   Optional build macro: SEQ_DIVMOD_SIGNED_EN adds the sgn input and
//   two's-complement operation (truncating quotient, remainder follows the
//   dividend's sign). Without it the unit is purely unsigned.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   sgn          in   1      (SEQ_DIVMOD_SIGNED_EN only) 1 = signed operation
//   start        in   1      request, sampled only while idle
//   a            in   WIDTH  dividend, captured on accepted start
//   b            in   WIDTH  divisor, captured on accepted start
//   busy         out  1      operation in flight (CALC or DONE state)
//   done         out  1      one-cycle pulse, results valid from this cycle
//   quotient     out  WIDTH  registered quotient, held until next done
//   remainder    out  WIDTH  registered remainder, held until next done
//   div_by_zero  out  1      registered flag, updated with done
// ----------------------------------------------------------------------------
module seq_divmod #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SEQ_DIVMOD_SIGNED_EN
   input  logic             sgn,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;     // partial remainder (raw a on divide-by-zero)
   logic [WIDTH-1:0] quo_q;     // dividend shifts out as quotient shifts in
   logic [WIDTH-1:0] div_q;     // divisor magnitude
   logic             dbz_q;
   logic             quo_neg_q; // negate quotient on write-back
   logic             rem_neg_q; // negate remainder on write-back
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;

   logic [WIDTH:0]   shifted_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] a_mag_d;
   logic [WIDTH-1:0] b_mag_d;
   logic             quo_neg_d;
   logic             rem_neg_d;
   logic [WIDTH-1:0] quo_res_d;
   logic [WIDTH-1:0] rem_res_d;

   // One restoring step. The shifted partial remainder needs WIDTH+1 bits;
   // the MSB of the trial difference is the borrow.
   always_comb begin
      shifted_d = {rem_q, quo_q[WIDTH-1]};
      trial_d   = shifted_d - {1'b0, div_q};
      rem_d     = trial_d[WIDTH] ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
   end

   // Operand magnitudes, result sign flags and sign-corrected results.
   always_comb begin
`ifdef SEQ_DIVMOD_SIGNED_EN
      a_mag_d   = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag_d   = (sgn && b[WIDTH-1]) ? -b : b;
      quo_neg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rem_neg_d = sgn && a[WIDTH-1];
`else
      a_mag_d   = a;
      b_mag_d   = b;
      quo_neg_d = 1'b0;
      rem_neg_d = 1'b0;
`endif
      quo_res_d = quo_neg_q ? -quo_q : quo_q;
      rem_res_d = rem_neg_q ? -rem_q : rem_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         div_q         <= '0;
         dbz_q         <= 1'b0;
         quo_neg_q     <= 1'b0;
         rem_neg_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  quo_neg_q <= quo_neg_d;
                  rem_neg_q <= rem_neg_d;
                  if (b == '0) begin
                     // Skip the iterations; remainder reports the raw dividend.
                     state_q <= S_DONE;
                     dbz_q   <= 1'b1;
                     rem_q   <= a;
                  end else begin
                     state_q <= S_CALC;
                     dbz_q   <= 1'b0;
                     rem_q   <= '0;
                     quo_q   <= a_mag_d;
                     div_q   <= b_mag_d;
                     cnt_q   <= '0;
                  end
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // Results and done are written on the same edge; sign fix-up
               // happens here so latency does not depend on sgn.
               state_q       <= S_IDLE;
               busy_q        <= 1'b0;
               done_q        <= 1'b1;
               quotient_q    <= dbz_q ? '1 : quo_res_d;
               remainder_q   <= dbz_q ? rem_q : rem_res_d;
               div_by_zero_q <= dbz_q;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divmod.sv
// ----------------------------------------------------------------------------
// tb_seq_divmod
//   Self-checking bench for seq_divmod: a 32-bit instance driven from a
//   vector table, hand-written handshake/reset sequences and random operands,
//   plus an 8-bit instance swept and randomised against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_seq_divmod;

   logic        clk;
   logic        reset;

   logic        start32, sgn32;
   logic [31:0] a32, b32, q32, r32;
   logic        busy32, done32, dbz32;

   logic        start8;
   logic [7:0]  a8, b8, q8, r8;
   logic        busy8, done8, dbz8;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_divmod #(.WIDTH(32)) dut32 (
      .clk        (clk),
      .reset      (reset),
`ifdef SEQ_DIVMOD_SIGNED_EN
      .sgn        (sgn32),
`endif
      .start      (start32),
      .a          (a32),
      .b          (b32),
      .busy       (busy32),
      .done       (done32),
      .quotient   (q32),
      .remainder  (r32),
      .div_by_zero(dbz32)
   );

   seq_divmod #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
`ifdef SEQ_DIVMOD_SIGNED_EN
      .sgn        (1'b0),
`endif
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .busy       (busy8),
      .done       (done8),
      .quotient   (q8),
      .remainder  (r8),
      .div_by_zero(dbz8)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sg;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
      logic        exp_dz;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Arithmetic reference: divide-by-zero convention, otherwise plain / and %.
   // Signed case uses 64-bit arithmetic so MIN / -1 wraps back to MIN.
   function automatic void ref32(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                                 output logic [31:0] q, output logic [31:0] r, output logic dz);
      longint sa, sb, sq, sr;
      if (bi == 32'd0) begin
         q  = '1;
         r  = ai;
         dz = 1'b1;
      end else if (si) begin
         sa = longint'($signed(ai));
         sb = longint'($signed(bi));
         sq = sa / sb;
         sr = sa % sb;
         q  = sq[31:0];
         r  = sr[31:0];
         dz = 1'b0;
      end else begin
         q  = ai / bi;
         r  = ai % bi;
         dz = 1'b0;
      end
   endfunction

   // Issue one 32-bit operation and wait (bounded) for done. lat counts edges
   // after the start edge until done is visible; -1 means timeout.
   task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                       output int lat, output logic busy1, output logic done_after);
      a32 = ai; b32 = bi; sgn32 = si; start32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      busy1 = busy32;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (done32) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      done_after = done32;
   endtask

   task automatic op8(input logic [7:0] ai, input logic [7:0] bi, output int lat);
      a8 = ai; b8 = bi; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (done8) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, n_done;
      logic        busy1, done_after, dz;
      logic [31:0] eq, er, ra, rb;
      logic [7:0]  ea8, eb8;
      logic        rs;

      start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
      start8  = 1'b0; a8 = '0; b8 = '0;

      // ---------------- reset state ----------------
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_outputs32", {27'd0, busy32, done32, dbz32, q32 != 0, r32 != 0}, 64'd0);
      check("reset_outputs8", {48'd0, busy8, done8, dbz8, 5'd0, q8, r8} & 64'hFFFF_FFFF, 64'd0);

      // ---------------- vector table ----------------
      vecs.push_back('{32'd14,         32'd5,          1'b0, 32'd2,          32'd4,   1'b0, 33});
      vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,   1'b0, 33});
      vecs.push_back('{32'd3,          32'h8000_0000,  1'b0, 32'd0,          32'd3,   1'b0, 33});
      vecs.push_back('{32'd100,        32'd0,          1'b0, 32'hFFFF_FFFF,  32'd100, 1'b1, 1});
      vecs.push_back('{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,   1'b0, 33});
      vecs.push_back('{32'd0,          32'd7,          1'b0, 32'd0,          32'd0,   1'b0, 33});
      vecs.push_back('{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,   1'b0, 33});
      vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,   1'b0, 33});
      vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,   1'b0, 33});
      vecs.push_back('{32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd0,   1'b1, 1});
`ifdef SEQ_DIVMOD_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,   1'b0, 33});
      vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,   1'b0, 33});
      vecs.push_back('{32'hFFFF_FF9C,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FF9C, 1'b1, 1});
`endif

      foreach (vecs[i]) begin
         op32(vecs[i].a, vecs[i].b, vecs[i].sg, lat, busy1, done_after);
         check($sformatf("vec%0d_busy", i), {63'd0, busy1}, 64'd1);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("vec%0d_qr", i), {q32, r32}, {vecs[i].exp_q, vecs[i].exp_r});
         check($sformatf("vec%0d_dbz", i), {63'd0, dbz32}, {63'd0, vecs[i].exp_dz});
         check($sformatf("vec%0d_done_pulse", i), {63'd0, done_after}, 64'd0);
      end

      // ---------------- start while busy is ignored ----------------
      a32 = 32'd50; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      repeat (9) @(negedge clk);
      a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0003;
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         if (done32) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      check("busy_ignore_done", {63'd0, lat >= 0}, 64'd1);
      check("busy_ignore_qr", {q32, r32}, {32'd7, 32'd1});
      @(negedge clk);
      check("busy_ignore_no_second_op", {62'd0, busy32, done32}, 64'd0);

      // ---------------- reset mid-CALC aborts ----------------
      a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_outputs", {q32, r32}, 64'd0);
      check("abort_flags", {61'd0, busy32, done32, dbz32}, 64'd0);
      n_done = 0;
      for (int k = 0; k < 60; k++) begin
         if (done32) n_done++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(n_done), 64'd0);

      // ---------------- random 32-bit vs model ----------------
      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 15));
            1:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
`ifdef SEQ_DIVMOD_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ref32(ra, rb, rs, eq, er, dz);
         op32(ra, rb, rs, lat, busy1, done_after);
         check($sformatf("rnd32_%0d a=%h b=%h s=%0d", i, ra, rb, rs),
               {q32, r32}, {eq, er});
         check($sformatf("rnd32_%0d_dbz_lat", i), {31'd0, dbz32, 32'(lat)},
               {31'd0, dz, (rb == 0) ? 32'd1 : 32'd33});
      end

      // ---------------- 8-bit sweeps and random ----------------
      for (int bi = 1; bi < 256; bi++) begin
         ea8 = 8'hFF;
         eb8 = 8'(bi);
         op8(ea8, eb8, lat);
         check($sformatf("sw8_max_b%0d", bi), {40'd0, 8'(lat), q8, r8},
               {40'd0, 8'd9, ea8 / eb8, ea8 % eb8});
         ea8 = 8'(bi - 1);
         op8(ea8, eb8, lat);
         check($sformatf("sw8_below_b%0d", bi), {40'd0, 8'(lat), q8, r8},
               {40'd0, 8'd9, 8'd0, ea8});
      end
      for (int i = 0; i < 1500; i++) begin
         ea8 = 8'($urandom);
         eb8 = 8'($urandom_range(1, 255));
         op8(ea8, eb8, lat);
         check($sformatf("rnd8_%0d a=%0d b=%0d", i, ea8, eb8),
               {40'd0, 8'(lat), q8, r8}, {40'd0, 8'd9, ea8 / eb8, ea8 % eb8});
      end
      op8(8'd77, 8'd0, lat);
      check("w8_div_zero", {39'd0, dbz8, 8'(lat), q8, r8}, {39'd0, 1'b1, 8'd1, 8'hFF, 8'd77});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
